lock_input_conditioner: RTL

- Front-end stage for the code-lock datapath: takes raw, asynchronous push-button/switch levels (clear button plus code inputs) and delivers clean, synchronized, debounced levels and single-cycle press/release pulses.
- The lock's state flops and polarity flops sample only these outputs, never raw pins.
- Per-channel 2-FF synchronizer, consecutive-sample debounce counter, edge detector, plus a multi-press (chord) flag.

---
 rtl/lock_input_conditioner.sv | 98 +++++++++
 1 files changed

// File: rtl/lock_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : lock_input_conditioner
// Description : Per-channel 2-FF sync, consecutive-sample debounce, edge pulses
//               and a chord (multi-press) flag for the code-lock front end.
// Revision    : 1.0 - initial release
// ============================================================================
module lock_input_conditioner #(
    parameter int N_CH      = 4,
    parameter int DEB_COUNT = 1000,
    parameter int CNT_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic            multi_press
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEB_COUNT - 1);

    logic [N_CH-1:0]  sync1_q;
    logic [N_CH-1:0]  sync2_q;
    logic [N_CH-1:0]  level_q;
    logic [N_CH-1:0]  level_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  press_q;
    logic [N_CH-1:0]  press_d;
    logic [N_CH-1:0]  release_q;
    logic [N_CH-1:0]  release_d;
    logic             multi_q;
    logic             multi_d;

    // Synchronizer runs regardless of ena so s2 is always current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i]     = cnt_q[i];
            level_d[i]   = level_q[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
            if (ena) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == c_cnt_max) begin
                    level_d[i]   = sync2_q[i];
                    cnt_d[i]     = '0;
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        // x & (x-1) clears the lowest set bit: non-zero iff two or more bits set.
        multi_d = |(press_d & (press_d - N_CH'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            multi_q   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            multi_q   <= multi_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign multi_press = multi_q;

endmodule
`default_nettype wire
